// File: rtl/pipeline_pkg.sv
// Shared types and widths for the MEM/WB writeback stage: data/index widths,
// the writeback FSM state encoding and the MEM/WB bundle layout.
package pipeline_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int CNT_W    = 8;
  localparam int RETIRE_W = 16;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_MEM
  } wb_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] alu_result;
  } mem_wb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB bundle, data-memory return and register-file write port of the writeback stage.
// The fwd_* bypass signals exist only when WB_FORWARD_EN is defined.
interface writeback_stage_if;
  import pipeline_pkg::*;

  logic                in_valid;
  logic [ADDR_W-1:0]   in_rd;
  logic                in_reg_write;
  logic                in_mem_to_reg;
  logic [DATA_W-1:0]   in_alu_result;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rvalid;
  logic                flush;
  logic [ADDR_W-1:0]   write_addr;
  logic [DATA_W-1:0]   write_data;
  logic                write_en;
  logic                stall_out;
  logic                load_err;
  logic [RETIRE_W-1:0] retire_count;
`ifdef WB_FORWARD_EN
  logic                fwd_valid;
  logic [ADDR_W-1:0]   fwd_addr;
  logic [DATA_W-1:0]   fwd_data;
`endif

  modport master (
    output in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
    output mem_rdata, mem_rvalid, flush,
`ifdef WB_FORWARD_EN
    input  fwd_valid, fwd_addr, fwd_data,
`endif
    input  write_addr, write_data, write_en, stall_out, load_err, retire_count
  );

  modport slave (
    input  in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
    input  mem_rdata, mem_rvalid, flush,
`ifdef WB_FORWARD_EN
    output fwd_valid, fwd_addr, fwd_data,
`endif
    output write_addr, write_data, write_en, stall_out, load_err, retire_count
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Load-wait cycle counter: clear has priority over enable; tc_o flags the cycle on
// which the count would reach TIMEOUT.
module wb_timeout_counter
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: writes ALU or load results into the register file, stalls upstream
// while a load is outstanding, and counts retired writes. Define WB_FORWARD_EN for fwd_* bypass.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave bus
);

  mem_wb_t             bundle;
  wb_state_t           state_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   write_addr_q;
  logic [DATA_W-1:0]   write_data_q;
  logic                write_en_q;
  logic                stall_q;
  logic                load_err_q;
  logic [RETIRE_W-1:0] retire_count_q;

  logic timeout_tc;
  logic alu_fire;
  logic load_start;
  logic mem_fire;
  logic timeout_fire;
  logic wr_fire;

  assign bundle = '{
    valid:      bus.in_valid,
    rd:         bus.in_rd,
    reg_write:  bus.in_reg_write,
    mem_to_reg: bus.in_mem_to_reg,
    alu_result: bus.in_alu_result
  };

  // flush overrides every event below, including a same-cycle rvalid or timeout
  assign alu_fire     = !bus.flush && (state_q == IDLE) && bundle.valid && bundle.reg_write
                        && !bundle.mem_to_reg;
  assign load_start   = !bus.flush && (state_q == IDLE) && bundle.valid && bundle.reg_write
                        && bundle.mem_to_reg;
  assign mem_fire     = !bus.flush && (state_q == WAIT_MEM) && bus.mem_rvalid;
  assign timeout_fire = !bus.flush && (state_q == WAIT_MEM) && !bus.mem_rvalid && timeout_tc;
  assign wr_fire      = alu_fire || mem_fire;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  ((state_q != WAIT_MEM) || bus.flush),
    .enable_i (state_q == WAIT_MEM),
    .tc_o     (timeout_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      rd_q           <= '0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      write_en_q     <= 1'b0;
      stall_q        <= 1'b0;
      load_err_q     <= 1'b0;
      retire_count_q <= '0;
    end else begin
      write_en_q <= wr_fire;
      load_err_q <= timeout_fire;
      if (wr_fire) begin
        retire_count_q <= retire_count_q + RETIRE_W'(1);
        write_addr_q   <= alu_fire ? bundle.rd : rd_q;
        write_data_q   <= alu_fire ? bundle.alu_result : bus.mem_rdata;
      end
      if (bus.flush) begin
        state_q <= IDLE;
        stall_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_start) begin
              rd_q    <= bundle.rd;
              state_q <= WAIT_MEM;
              stall_q <= 1'b1;
            end
          end
          WAIT_MEM: begin
            if (mem_fire || timeout_fire) begin
              state_q <= IDLE;
              stall_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.write_addr   = write_addr_q;
  assign bus.write_data   = write_data_q;
  assign bus.write_en     = write_en_q;
  assign bus.stall_out    = stall_q;
  assign bus.load_err     = load_err_q;
  assign bus.retire_count = retire_count_q;

`ifdef WB_FORWARD_EN
  // Bypass stays valid for the write cycle and one cycle after; addr/data hold meanwhile
  logic fwd_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
    end else begin
      fwd_valid_q <= wr_fire || write_en_q;
    end
  end

  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_addr  = write_addr_q;
  assign bus.fwd_data  = write_data_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected writes/errors,
// a negedge monitor pops and compares them whenever write_en or load_err is seen.
module tb_writeback_stage;
  import pipeline_pkg::*;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_if bus ();

  writeback_stage #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit                  is_err;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [RETIRE_W-1:0] retire;
  } exp_t;

  exp_t                sb[$];
  int                  checks = 0;
  int                  errors = 0;
  logic [RETIRE_W-1:0] exp_retire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bundle();
    bus.in_valid      = 1'b0;
    bus.in_rd         = '0;
    bus.in_reg_write  = 1'b0;
    bus.in_mem_to_reg = 1'b0;
    bus.in_alu_result = '0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_mem_to_reg = m2r;
    bus.in_rd         = rd;
    bus.in_alu_result = d;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    exp_retire = exp_retire + RETIRE_W'(1);
    e.is_err = 1'b0;
    e.addr   = a;
    e.data   = d;
    e.retire = exp_retire;
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.addr   = '0;
    e.data   = '0;
    e.retire = exp_retire;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
`ifdef WB_FORWARD_EN
    logic prev_wen = 1'b0;
`endif
    forever begin
      @(negedge clk);
`ifdef WB_FORWARD_EN
      check("fwd_valid", 32'(bus.fwd_valid), 32'(bus.write_en || prev_wen));
      if (bus.fwd_valid) begin
        check("fwd_addr", 32'(bus.fwd_addr), 32'(bus.write_addr));
        check("fwd_data", 32'(bus.fwd_data), 32'(bus.write_data));
      end
      prev_wen = bus.write_en;
`endif
      if (bus.write_en || bus.load_err) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'({bus.write_en, bus.load_err}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ev_load_err", 32'(bus.load_err), 32'(e.is_err));
          check("ev_write_en", 32'(bus.write_en), 32'(!e.is_err));
          check("ev_retire", 32'(bus.retire_count), 32'(e.retire));
          if (!e.is_err) begin
            check("ev_addr", 32'(bus.write_addr), 32'(e.addr));
            check("ev_data", 32'(bus.write_data), 32'(e.data));
            $display("[%0t] write addr=%0d data=%h retire=%h", $time, bus.write_addr,
                     bus.write_data, bus.retire_count);
          end else begin
            $display("[%0t] load timeout retire=%h", $time, bus.retire_count);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    clear_bundle();
    exp_retire = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_en", 32'(bus.write_en), 32'd0);
    check("rst_write_addr", 32'(bus.write_addr), 32'd0);
    check("rst_write_data", 32'(bus.write_data), 32'd0);
    check("rst_stall", 32'(bus.stall_out), 32'd0);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    check("rst_retire", 32'(bus.retire_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // ALU writes, back to back
    drive(1'b1, 1'b1, 1'b0, 3'd3, 16'h1234); expect_write(3'd3, 16'h1234); step();
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h0001); expect_write(3'd1, 16'h0001); step();
    drive(1'b1, 1'b1, 1'b0, 3'd7, 16'hFFFF); expect_write(3'd7, 16'hFFFF); step();
    // Non-writing bundle, then stray rvalid in IDLE: neither writes
    drive(1'b1, 1'b0, 1'b0, 3'd2, 16'hDEAD); step();
    clear_bundle();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h9999; step();
    bus.mem_rvalid = 1'b0; step();
    check("hold_addr", 32'(bus.write_addr), 32'd7);
    check("hold_data", 32'(bus.write_data), 32'hFFFF);
    check("idle_stall", 32'(bus.stall_out), 32'd0);

    // Load answered 4 cycles later; a held ALU bundle during the wait is ignored
    drive(1'b1, 1'b1, 1'b1, 3'd5, 16'hAAAA); step();
    check("load_stall_c1", 32'(bus.stall_out), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 3'd2, 16'h5555);
    repeat (3) begin
      step();
      check("load_stall", 32'(bus.stall_out), 32'd1);
    end
    clear_bundle();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hBEEF; expect_write(3'd5, 16'hBEEF); step();
    bus.mem_rvalid = 1'b0;
    check("load_stall_drop", 32'(bus.stall_out), 32'd0);
    step();

    // Timeout, then late data is ignored
    drive(1'b1, 1'b1, 1'b1, 3'd6, 16'h0000); step(); clear_bundle();
    check("to_stall_c1", 32'(bus.stall_out), 32'd1);
    repeat (14) step();
    check("to_stall_c14", 32'(bus.stall_out), 32'd1);
    check("to_no_err_early", 32'(bus.load_err), 32'd0);
    expect_err(); step();
    check("to_stall_drop", 32'(bus.stall_out), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h7777; step();
    bus.mem_rvalid = 1'b0; step();

    // rvalid exactly on the timeout cycle is accepted
    drive(1'b1, 1'b1, 1'b1, 3'd4, 16'h0000); step(); clear_bundle();
    repeat (14) step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h0F0F; expect_write(3'd4, 16'h0F0F); step();
    bus.mem_rvalid = 1'b0;
    check("tc_rvalid_stall", 32'(bus.stall_out), 32'd0);
    step();

    // Flush beats rvalid during WAIT_MEM
    drive(1'b1, 1'b1, 1'b1, 3'd2, 16'h0000); step(); clear_bundle(); step();
    bus.flush = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h1111; step();
    bus.flush = 1'b0; bus.mem_rvalid = 1'b0;
    check("flush_stall", 32'(bus.stall_out), 32'd0);
    check("flush_retire", 32'(bus.retire_count), 32'(exp_retire));
    repeat (20) step();
    // Flush in IDLE drops the bundle; the next one writes normally
    drive(1'b1, 1'b1, 1'b0, 3'd6, 16'h6666); bus.flush = 1'b1; step();
    bus.flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h2222); expect_write(3'd1, 16'h2222); step();
    clear_bundle(); step();

    // Reset mid-load: outputs clear at once, later rvalid writes nothing
    drive(1'b1, 1'b1, 1'b1, 3'd3, 16'h0000); step(); clear_bundle(); step();
    check("pre_rst_stall", 32'(bus.stall_out), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_stall", 32'(bus.stall_out), 32'd0);
    check("mid_rst_write_en", 32'(bus.write_en), 32'd0);
    check("mid_rst_addr", 32'(bus.write_addr), 32'd0);
    check("mid_rst_data", 32'(bus.write_data), 32'd0);
    check("mid_rst_retire", 32'(bus.retire_count), 32'd0);
    exp_retire = '0;
    @(negedge clk);
    reset = 1'b0;
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h4444; step();
    bus.mem_rvalid = 1'b0; step();
    check("post_rst_stall", 32'(bus.stall_out), 32'd0);

    // Retire counter wrap
    force dut.retire_count_q = 16'hFFFE;
    #1;
    release dut.retire_count_q;
    exp_retire = 16'hFFFE;
    drive(1'b1, 1'b1, 1'b0, 3'd2, 16'hAB01); expect_write(3'd2, 16'hAB01); step();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 16'hAB02); expect_write(3'd0, 16'hAB02); step();
    clear_bundle();
    repeat (3) step();
    check("wrap_retire", 32'(bus.retire_count), 32'h0000);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
